// File: rtl/jjh_drain_pkg.sv
// rtl/jjh_drain_pkg.sv - shared sizes, drain FSM states and the requant rule
package jjh_drain_pkg;

  localparam int LANES      = 64;
  localparam int IN_W       = 16;
  localparam int OUT_W      = 8;
  localparam int BEAT_LANES = 8;
  localparam int BEATS      = LANES / BEAT_LANES;
  localparam int SHIFT_DEF  = 4;

  typedef enum logic {
    IDLE,
    DRAIN
  } state_e;

  // ReLU, arithmetic shift, then clamp to the unsigned output range.
  function automatic logic [OUT_W-1:0] requant(input logic signed [IN_W-1:0] x,
                                               input int shift);
    logic signed [IN_W-1:0] y;
    y = x >>> shift;
    if (x[IN_W-1]) return '0;
    if (|y[IN_W-1:OUT_W]) return '1;
    return y[OUT_W-1:0];
  endfunction

endpackage

// File: rtl/requant_lane.sv
// rtl/requant_lane.sv - one lane of ReLU + shift-and-saturate requantization
module requant_lane
  import jjh_drain_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic [IN_W-1:0]  x_i,
  output logic [OUT_W-1:0] y_o
);

  assign y_o = requant(x_i, SHIFT);

endmodule

// File: rtl/loop3_result_drain.sv
// rtl/loop3_result_drain.sv - captures one accumulated vector and drains it as
// eight requantized beats, stalling the accumulator while the buffer is full
module loop3_result_drain
  import jjh_drain_pkg::*;
#(
  parameter int SHIFT = SHIFT_DEF
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_v,
  input  logic [LANES*IN_W-1:0]         in_data,
  output logic                          halt,
  output logic                          out_v,
  input  logic                          out_ready,
  output logic [BEAT_LANES*OUT_W-1:0]   out_data,
  output logic                          out_last,
  output logic                          busy
);

  localparam int BEAT_W  = $clog2(BEATS);
  localparam int SLICE_W = BEAT_LANES * IN_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

  state_e                  state_q, state_d;
  logic [BEAT_W-1:0]       beat_cnt_q, beat_cnt_d;
  logic [LANES*IN_W-1:0]   buf_q, buf_d;
  logic                    last_hs;
  logic [SLICE_W-1:0]      beat_slice;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      buf_q      <= '0;
    end else begin
      state_q    <= state_d;
      beat_cnt_q <= beat_cnt_d;
      buf_q      <= buf_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    beat_cnt_d = beat_cnt_q;
    buf_d      = buf_q;
    out_v      = 1'b0;
    halt       = 1'b0;
    out_last   = 1'b0;
    last_hs    = 1'b0;
    case (state_q)
      IDLE: begin
        if (in_v) begin
          buf_d      = in_data;
          beat_cnt_d = '0;
          state_d    = DRAIN;
        end
      end
      DRAIN: begin
        out_v    = 1'b1;
        out_last = (beat_cnt_q == LAST_BEAT);
        last_hs  = out_last && out_ready;
        // Releasing halt on the final handshake lets a waiting vector land
        // on the same edge, so back-to-back vectors have no bubble.
        halt     = !last_hs;
        if (out_ready) beat_cnt_d = beat_cnt_q + 1'b1;
        if (last_hs) begin
          if (in_v) begin
            buf_d      = in_data;
            beat_cnt_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy       = (state_q == DRAIN);
  assign beat_slice = buf_q[int'(beat_cnt_q) * SLICE_W +: SLICE_W];

  for (genvar j = 0; j < BEAT_LANES; j++) begin : g_lane
    requant_lane #(
      .SHIFT(SHIFT)
    ) u_requant (
      .x_i(beat_slice[j*IN_W +: IN_W]),
      .y_o(out_data[j*OUT_W +: OUT_W])
    );
  end

endmodule

// File: tb/tb_loop3_result_drain.sv
// tb/tb_loop3_result_drain.sv - self-checking bench for loop3_result_drain
module tb_loop3_result_drain;

  logic          clk;
  logic          rst;
  logic          in_v;
  logic [1023:0] in_data;
  logic          halt;
  logic          out_v;
  logic          out_ready;
  logic [63:0]   out_data;
  logic          out_last;
  logic          busy;

  int n_cmp  = 0;
  int n_fail = 0;

  loop3_result_drain dut (
    .clk      (clk),
    .rst      (rst),
    .in_v     (in_v),
    .in_data  (in_data),
    .halt     (halt),
    .out_v    (out_v),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_last (out_last),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int model_rq(input logic signed [15:0] x);
    int v;
    v = x;
    if (v < 0) return 0;
    v = v / 16;
    return (v > 255) ? 255 : v;
  endfunction

  function automatic logic [63:0] exp_beat(input logic [1023:0] v, input int b);
    logic [63:0] r;
    int q;
    r = '0;
    for (int j = 0; j < 8; j++) begin
      q = model_rq(v[(8*b+j)*16 +: 16]);
      r[8*j +: 8] = q[7:0];
    end
    return r;
  endfunction

  function automatic logic [1023:0] rand_vec();
    logic [1023:0] v;
    for (int k = 0; k < 32; k++) v[32*k +: 32] = $urandom;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    #4;
  endtask

  task automatic test_reset();
    rst = 1'b0; in_v = 1'b0; out_ready = 1'b0; in_data = '0;
    tick(); tick();
    mid();
    n_cmp++;
    if (out_v !== 1'b0 || halt !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL reset: v=%b halt=%b busy=%b last=%b data=%h, want all 0", out_v, halt, busy, out_last, out_data);
    end
    tick();
    rst = 1'b1;
    mid();
    n_cmp++;
    if (out_v !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_release: v=%b busy=%b, want 0 0", out_v, busy);
    end
    tick();
  endtask

  task automatic test_single();
    logic [1023:0] vec;
    logic [63:0]   want;
    for (int i = 0; i < 64; i++) vec[16*i +: 16] = 16'(16 * i);
    in_data = vec; in_v = 1'b1; out_ready = 1'b1;
    mid();
    n_cmp++;
    if (out_v !== 1'b0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: v=%b halt=%b, want 0 0", out_v, halt);
    end
    tick();
    in_v = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 8; j++) want[8*j +: 8] = 8'(8*b + j);
      mid();
      n_cmp++;
      if (out_v !== 1'b1 || out_data !== want || out_last !== (b == 7) || halt !== (b != 7) || busy !== 1'b1) begin
        n_fail++;
        $display("FAIL single_beat%0d: v=%b data=%h last=%b halt=%b busy=%b, want 1 %h %b %b 1",
                 b, out_v, out_data, out_last, halt, busy, want, (b == 7), (b != 7));
      end
      tick();
    end
    mid();
    n_cmp++;
    if (out_v !== 1'b0 || busy !== 1'b0 || halt !== 1'b0) begin
      n_fail++;
      $display("FAIL single_end: v=%b busy=%b halt=%b, want 0 0 0", out_v, busy, halt);
    end
    tick();
  endtask

  task automatic test_saturate();
    logic [1023:0] vec;
    logic [63:0]   want;
    for (int i = 0; i < 64; i++) vec[16*i +: 16] = (i % 2 == 0) ? 16'h7FFF : 16'h8000;
    vec[5*16 +: 16] = 16'h0FF0;
    in_data = vec; in_v = 1'b1; out_ready = 1'b1;
    tick();
    in_v = 1'b0;
    for (int b = 0; b < 8; b++) begin
      for (int j = 0; j < 8; j++) want[8*j +: 8] = (j % 2 == 0 || (b == 0 && j == 5)) ? 8'hFF : 8'h00;
      mid();
      n_cmp++;
      if (out_data !== want) begin
        n_fail++;
        $display("FAIL saturate_beat%0d: data=%h, want %h", b, out_data, want);
      end
      tick();
    end
    vec = '0;
    vec[15:0] = 16'h7FFF; vec[31:16] = 16'h00F0; vec[47:32] = 16'hFFFF; vec[63:48] = 16'h000F;
    in_data = vec; in_v = 1'b1;
    tick();
    in_v = 1'b0;
    mid();
    n_cmp++;
    if (out_data[31:0] !== 32'h00_00_0F_FF) begin
      n_fail++;
      $display("FAIL requant_examples: data=%h, want 000000000000_0FFF low word 00000fff", out_data);
    end
    for (int b = 0; b < 8; b++) tick();
  endtask

  task automatic test_backpressure();
    logic [1023:0] vec;
    int hs;
    vec = rand_vec();
    in_data = vec; in_v = 1'b1; out_ready = 1'b1;
    tick();
    in_v = 1'b0;
    hs = 0;
    for (int cyc = 0; cyc < 64 && hs < 8; cyc++) begin
      out_ready = (cyc % 3 == 0);
      mid();
      n_cmp++;
      if (out_v !== 1'b1 || out_data !== exp_beat(vec, hs) || out_last !== (hs == 7) ||
          halt !== !(hs == 7 && out_ready)) begin
        n_fail++;
        $display("FAIL backpressure_cyc%0d: v=%b data=%h last=%b halt=%b, want 1 %h %b %b",
                 cyc, out_v, out_data, out_last, halt, exp_beat(vec, hs), (hs == 7), !(hs == 7 && out_ready));
      end
      if (out_ready) hs++;
      tick();
    end
    out_ready = 1'b1;
    mid();
    n_cmp++;
    if (hs !== 8 || out_v !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL backpressure_end: handshakes=%0d v=%b busy=%b, want 8 0 0", hs, out_v, busy);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    logic [1023:0] va, vb;
    va = rand_vec();
    vb = rand_vec();
    in_data = va; in_v = 1'b1; out_ready = 1'b1;
    tick();
    in_data = vb;
    for (int b = 0; b < 8; b++) begin
      mid();
      n_cmp++;
      if (out_v !== 1'b1 || out_data !== exp_beat(va, b) || halt !== (b != 7)) begin
        n_fail++;
        $display("FAIL b2b_A_beat%0d: v=%b data=%h halt=%b, want 1 %h %b", b, out_v, out_data, halt, exp_beat(va, b), (b != 7));
      end
      tick();
    end
    in_v = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mid();
      n_cmp++;
      if (out_v !== 1'b1 || out_data !== exp_beat(vb, b) || out_last !== (b == 7)) begin
        n_fail++;
        $display("FAIL b2b_B_beat%0d: v=%b data=%h last=%b, want 1 %h %b", b, out_v, out_data, out_last, exp_beat(vb, b), (b == 7));
      end
      tick();
    end
    mid();
    n_cmp++;
    if (out_v !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_end: v=%b busy=%b, want 0 0", out_v, busy);
    end
    tick();
  endtask

  task automatic test_reset_mid_drain();
    logic [1023:0] va, vb;
    va = rand_vec();
    vb = rand_vec();
    in_data = va; in_v = 1'b1; out_ready = 1'b1;
    tick();
    in_v = 1'b0;
    for (int b = 0; b < 4; b++) begin
      mid();
      n_cmp++;
      if (out_data !== exp_beat(va, b)) begin
        n_fail++;
        $display("FAIL rstmid_beat%0d: data=%h, want %h", b, out_data, exp_beat(va, b));
      end
      tick();
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (out_v !== 1'b0 || halt !== 1'b0 || busy !== 1'b0 || out_last !== 1'b0 || out_data !== 64'h0) begin
      n_fail++;
      $display("FAIL rstmid_async: v=%b halt=%b busy=%b last=%b data=%h, want all 0", out_v, halt, busy, out_last, out_data);
    end
    tick();
    rst = 1'b1;
    mid();
    n_cmp++;
    if (out_v !== 1'b0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rstmid_idle: v=%b busy=%b, want 0 0", out_v, busy);
    end
    tick();
    in_data = vb; in_v = 1'b1;
    tick();
    in_v = 1'b0;
    for (int b = 0; b < 8; b++) begin
      mid();
      n_cmp++;
      if (out_v !== 1'b1 || out_data !== exp_beat(vb, b) || out_last !== (b == 7)) begin
        n_fail++;
        $display("FAIL rstmid_fresh_beat%0d: v=%b data=%h last=%b, want 1 %h %b", b, out_v, out_data, out_last, exp_beat(vb, b), (b == 7));
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [64:0] exp_q[$];
    logic        exp_halt, exp_busy, accepted;
    int          sent;
    int          cyc;
    sent = 0;
    in_v = 1'b0;
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (sent == 20 && exp_q.size() == 0 && !in_v) break;
      if (!in_v && sent < 20 && $urandom_range(0, 3) == 0) begin
        in_v    = 1'b1;
        in_data = rand_vec();
      end
      out_ready = ($urandom_range(0, 2) != 0);
      mid();
      exp_busy = (exp_q.size() != 0);
      exp_halt = exp_busy && !(exp_q[0][64] && out_ready);
      n_cmp++;
      if (out_v !== exp_busy || busy !== exp_busy || halt !== exp_halt) begin
        n_fail++;
        $display("FAIL random_ctl cyc%0d: v=%b busy=%b halt=%b, want %b %b %b", cyc, out_v, busy, halt, exp_busy, exp_busy, exp_halt);
      end
      if (exp_busy) begin
        n_cmp++;
        if (out_data !== exp_q[0][63:0] || out_last !== exp_q[0][64]) begin
          n_fail++;
          $display("FAIL random_data cyc%0d: data=%h last=%b, want %h %b", cyc, out_data, out_last, exp_q[0][63:0], exp_q[0][64]);
        end
        if (out_ready) void'(exp_q.pop_front());
      end
      accepted = in_v && !exp_halt;
      if (accepted) begin
        for (int b = 0; b < 8; b++) exp_q.push_back({(b == 7), exp_beat(in_data, b)});
        sent++;
      end
      tick();
      if (accepted) in_v = 1'b0;
    end
    n_cmp++;
    if (sent !== 20 || exp_q.size() !== 0) begin
      n_fail++;
      $display("FAIL random_done: vectors=%0d pending_beats=%0d, want 20 0", sent, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_saturate();
    test_backpressure();
    test_back_to_back();
    test_reset_mid_drain();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/loop3_result_drain.md
# loop3_result_drain

Downstream stage of the channel-loop accumulator. It captures one finished 64-lane × 16-bit accumulated vector (1024 bits) at a time, applies ReLU and a shift-and-saturate requantization to 8 bits, and streams the result out as eight 64-bit beats over a valid/ready handshake. While a vector is being drained it asserts `halt` back to the accumulator, which freezes it until the buffer can accept the next vector.

## Interface
- `LANES`, 64: lanes per input vector.
- `IN_W`, 16: signed accumulator width per lane.
- `OUT_W`, 8: unsigned output width per lane.
- `BEAT_LANES`, 8: lanes per output beat; `LANES/BEAT_LANES` = 8 beats.
- `SHIFT`, 4: arithmetic right shift applied before saturation.

Ports:
- `clk` in 1: single clock.
- `rst` in 1: asynchronous, active-low reset.
- `in_v` in 1: accumulated vector valid (the accumulator's final-loop valid).
- `in_data` in 1024: lane i = `in_data[16i+15:16i]`, two's complement.
- `halt` out 1: upstream stall request.
- `out_v` out 1: output beat valid.
- `out_ready` in 1: downstream accepts the beat.
- `out_data` out 64: output lane j = `out_data[8j+7:8j]`.
- `out_last` out 1: marks beat 7 of a vector.
- `busy` out 1: a vector is held in the buffer.

## Operation
- **Buffer:** one 1024-bit capture register `buf`, a 3-bit `beat_cnt`, and FSM states IDLE and DRAIN.
- **IDLE:** `out_v`=0 and `halt`=0. When `in_v`=1, capture `in_data` into `buf`, clear `beat_cnt`, and go to DRAIN.
- **DRAIN:** `out_v`=1.
  - `out_data` lane j = requant(`buf` lane 8·`beat_cnt`+j).
  - `out_last` = (`beat_cnt`==7).
  - On `out_v && out_ready`, `beat_cnt` increments.
- **Last handshake** (`beat_cnt`==7 and `out_ready`):
  - If `in_v`=1 in the same cycle: capture the new vector, set `beat_cnt`=0, stay in DRAIN.
  - Otherwise go to IDLE.
- **halt:** `halt` = (state==DRAIN) && !(`beat_cnt`==7 && `out_ready`). It is combinational, so the upstream is released in the same cycle the final beat leaves.
- **in_v while halted:** ignored, no capture. The upstream is required to hold its vector and valid while halted.
- **requant(x):**
  - x<0 → 0 (ReLU).
  - Otherwise y = x >>> `SHIFT`; y>255 → 255, else y[7:0].
  - Example values: x=16'h7FFF → 255; x=16'h00F0 → 15; x=16'hFFFF → 0.
- **No ready:** with `out_ready`=0 in DRAIN, `out_data`, `out_last` and `beat_cnt` hold stable (AXI-style: valid never drops once raised until the handshake completes).
- **busy:** `busy` = (state==DRAIN).

## Timing
- Reset values: state IDLE, `beat_cnt`=0, `buf`=0, `out_v`=0, `out_last`=0, `out_data`=0, `halt`=0, `busy`=0.
- Reset mid-drain discards the vector; outputs return to reset values asynchronously.
- Latency: `in_v` sampled at edge N → `out_v`=1 with beat 0 after edge N (cycle N+1).
- Full drain takes a minimum of 8 cycles when `out_ready` is held at 1.
- Back-to-back throughput: one vector per 8 cycles with no bubble between beat 7 and the next beat 0.
- `out_data` and `out_last` are combinational from registered `buf` and `beat_cnt`. There is no combinational path from `in_data` to `out_data`.
- `halt` is the only output with a combinational dependency on an input (`out_ready`).

## Structure
- Shared package `jjh_drain_pkg`:
  - `LANES`, `IN_W`, `OUT_W`, `BEAT_LANES`, `BEATS`=8.
  - State enum {IDLE, DRAIN}.
  - A `requant` function.
- Sub-module `requant_lane` (`IN_W`→`OUT_W`, `SHIFT` parameter), instantiated `BEAT_LANES` times on the muxed beat slice.
- The top level holds the FSM, `buf`, `beat_cnt` and the beat mux.

## Test plan
- **Single vector:** reset, then `in_v` pulse with lane i = 16·i, `out_ready`=1.
  - Expect 8 beats on cycles 1–8.
  - Beat b lane j = ((8b+j)·16)>>4 = 8b+j.
  - `out_last` only on beat 7; `halt`=1 on cycles 1–7 and 0 on cycle 8.
- **Saturate/ReLU:** lanes alternate 16'h7FFF and 16'h8000, plus lane 5 = 16'h0FF0.
  - Outputs alternate 255 and 0; lane 5 = 255.
- **Backpressure:** `out_ready` toggles 1,0,0,1,…
  - `out_data` stays stable while `out_ready`=0.
  - Exactly 8 handshakes occur, in order; `halt` stays high until the final handshake.
- **Back-to-back:** vector A, then vector B presented with `in_v` held while halted.
  - B is captured on A's beat-7 handshake.
  - B beat 0 appears the next cycle with no IDLE gap.
  - `in_v` during `halt` never corrupts A's beats.
- **Reset mid-drain:** assert `rst`=0 after beat 3.
  - All outputs go to 0 immediately.
  - After release the block is IDLE and a fresh vector drains from beat 0.
